// File: rtl/axi_stream_resizer_if.sv
// AXI4-Stream bundle (tdata/tkeep/tlast, valid/ready); no latency of its own.
// Backpressure rides on tready, driven by the sink through the s modport.
interface axi_stream_resizer_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0]   tdata;
  logic [WIDTH/8-1:0] tkeep;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport m (output tdata, tkeep, tlast, tvalid, input tready);
  modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axi_stream_resizer.sv
// AXI4-Stream width converter: passthrough, zero-latency downsize, or 1-cycle registered upsize.
// Backpressure: downsize holds the input until its final slice leaves; upsize stalls only a completing beat.
module axi_stream_resizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  axi_stream_resizer_if.s in,
  axi_stream_resizer_if.m out
);
  localparam int MAXW = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int MINW = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam int R    = MAXW / MINW;
  localparam int CW   = (R > 1) ? $clog2(R) : 1;
  localparam int IKB  = IN_WIDTH / 8;
  localparam int OKB  = OUT_WIDTH / 8;

  if (((IN_WIDTH & (IN_WIDTH - 1)) != 0) || ((OUT_WIDTH & (OUT_WIDTH - 1)) != 0) ||
      (IN_WIDTH < 8) || (OUT_WIDTH < 8) || (R > 16)) begin : g_bad_params
    $error("axi_stream_resizer: widths must be powers of two, >= 8, ratio <= 16");
  end

  if (IN_WIDTH == OUT_WIDTH) begin : g_pass
    assign out.tdata  = in.tdata;
    assign out.tkeep  = in.tkeep;
    assign out.tlast  = in.tlast;
    assign out.tvalid = in.tvalid;
    assign in.tready  = out.tready;

  end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
    logic [CW-1:0] slice_idx;
    logic [CW-1:0] final_idx;
    logic          is_final;

    // Final slice is the highest one carrying any byte; trailing empty slices are skipped.
    always_comb begin
      final_idx = '0;
      for (int s = 0; s < R; s++) begin
        if (|in.tkeep[s*OKB +: OKB]) final_idx = CW'(s);
      end
    end

    assign is_final   = (slice_idx >= final_idx);
    assign out.tdata  = in.tdata[slice_idx*OUT_WIDTH +: OUT_WIDTH];
    assign out.tkeep  = in.tkeep[slice_idx*OKB +: OKB];
    assign out.tlast  = in.tlast & is_final;
    assign out.tvalid = in.tvalid & ~rst;
    assign in.tready  = out.tready & is_final & ~rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        slice_idx <= '0;
      end else if (out.tvalid && out.tready) begin
        slice_idx <= is_final ? '0 : slice_idx + 1'b1;
      end
    end

  end else begin : g_up
    logic [CW-1:0]        lane;
    logic [OUT_WIDTH-1:0] stage_data;
    logic [OKB-1:0]       stage_keep;
    logic [OUT_WIDTH-1:0] word_data;
    logic [OKB-1:0]       word_keep;
    logic [OUT_WIDTH-1:0] out_data;
    logic [OKB-1:0]       out_keep;
    logic                 out_last;
    logic                 out_vld;
    logic                 completing;
    logic                 accept;

    // A completing beat may only enter when the output register is free or draining this cycle.
    assign completing = (lane == CW'(R - 1)) || in.tlast;
    assign in.tready  = ~rst & (~completing | ~out_vld | out.tready);
    assign accept     = in.tvalid & in.tready;

    always_comb begin
      word_data = stage_data;
      word_keep = stage_keep;
      word_data[lane*IN_WIDTH +: IN_WIDTH] = in.tdata;
      word_keep[lane*IKB +: IKB]           = in.tkeep;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane       <= '0;
        stage_data <= '0;
        stage_keep <= '0;
        out_data   <= '0;
        out_keep   <= '0;
        out_last   <= 1'b0;
        out_vld    <= 1'b0;
      end else begin
        if (out_vld && out.tready) out_vld <= 1'b0;
        if (accept) begin
          if (completing) begin
            out_data   <= word_data;
            out_keep   <= word_keep;
            out_last   <= in.tlast;
            out_vld    <= 1'b1;
            lane       <= '0;
            stage_data <= '0;
            stage_keep <= '0;
          end else begin
            stage_data <= word_data;
            stage_keep <= word_keep;
            lane       <= lane + 1'b1;
          end
        end
      end
    end

    assign out.tdata  = out_data;
    assign out.tkeep  = out_keep;
    assign out.tlast  = out_last;
    assign out.tvalid = out_vld;
  end
endmodule

// File: tb/tb_axi_stream_resizer.sv
// Bench for axi_stream_resizer: four width configurations, directed tables and randomized streams.
module tb_axi_stream_resizer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  axi_stream_resizer_if #(.WIDTH(512)) a_in ();
  axi_stream_resizer_if #(.WIDTH(256)) a_out ();
  axi_stream_resizer_if #(.WIDTH(512)) b_in ();
  axi_stream_resizer_if #(.WIDTH(128)) b_out ();
  axi_stream_resizer_if #(.WIDTH(128)) c_in ();
  axi_stream_resizer_if #(.WIDTH(512)) c_out ();
  axi_stream_resizer_if #(.WIDTH(256)) e_in ();
  axi_stream_resizer_if #(.WIDTH(512)) e_out ();

  axi_stream_resizer #(.IN_WIDTH(512), .OUT_WIDTH(256)) dut_a (.clk(clk), .rst(rst), .in(a_in), .out(a_out));
  axi_stream_resizer #(.IN_WIDTH(512), .OUT_WIDTH(128)) dut_b (.clk(clk), .rst(rst), .in(b_in), .out(b_out));
  axi_stream_resizer #(.IN_WIDTH(128), .OUT_WIDTH(512)) dut_c (.clk(clk), .rst(rst), .in(c_in), .out(c_out));
  axi_stream_resizer #(.IN_WIDTH(256), .OUT_WIDTH(512)) dut_e (.clk(clk), .rst(rst), .in(e_in), .out(e_out));

  typedef struct {
    logic [63:0] keep;
    logic        last;
    int          n;
    logic [15:0] fkeep;
  } vec_t;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         fin;
  } rec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rnd_keep();
    logic [63:0] all1;
    all1 = '1;
    case ($urandom_range(0, 3))
      0: return all1;
      1: return '0;
      2: return all1 >> $urandom_range(0, 63);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic idle_all();
    a_in.tvalid = 0; a_in.tdata = '0; a_in.tkeep = '0; a_in.tlast = 0; a_out.tready = 0;
    b_in.tvalid = 0; b_in.tdata = '0; b_in.tkeep = '0; b_in.tlast = 0; b_out.tready = 0;
    c_in.tvalid = 0; c_in.tdata = '0; c_in.tkeep = '0; c_in.tlast = 0; c_out.tready = 0;
    e_in.tvalid = 0; e_in.tdata = '0; e_in.tkeep = '0; e_in.tlast = 0; e_out.tready = 0;
  endtask

  vec_t         tbl [6];
  logic [511:0] d;
  logic [127:0] bq [4];
  logic [255:0] eb [8];
  logic [511:0] got [$];
  logic         got_last [$];
  rec_t         expq [$];
  rec_t         e;
  rec_t         cur;
  int           bi, sent, cyc, lanes, hi;
  logic         hs, ihs, ohs, busy, hold;
  logic [511:0] hold_d;
  logic [63:0]  hold_k;
  logic         hold_l;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4, 16'hFFFF};
    tbl[1] = '{64'h0000_0000_0000_0000, 1'b1, 1, 16'h0000};
    tbl[2] = '{64'h0000_0000_FFFF_0000, 1'b0, 2, 16'hFFFF};
    tbl[3] = '{64'h0001_0000_0000_0000, 1'b1, 4, 16'h0001};
    tbl[4] = '{64'h0000_0000_0000_FFFF, 1'b1, 1, 16'hFFFF};
    tbl[5] = '{64'h0000_0080_0000_0000, 1'b0, 3, 16'h0080};

    // Reset: outputs idle and inputs refused even with traffic offered
    rst = 1'b1;
    idle_all();
    b_in.tvalid = 1; b_out.tready = 1; c_in.tvalid = 1; c_in.tlast = 1; c_out.tready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_out_vld", a_out.tvalid, 0);
    chk("rst_b_out_vld", b_out.tvalid, 0);
    chk("rst_b_in_rdy", b_in.tready, 0);
    chk("rst_c_in_rdy", c_in.tready, 0);
    chk("rst_c_out_vld", c_out.tvalid, 0);
    chk("rst_c_out_dat", c_out.tdata, 0);
    chk("rst_c_out_keep", c_out.tkeep, 0);
    chk("rst_c_out_last", c_out.tlast, 0);
    chk("rst_e_in_rdy", e_in.tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_all();

    // 512->256 full beat with tlast
    d = rnd512();
    a_in.tdata = d; a_in.tkeep = '1; a_in.tlast = 1; a_in.tvalid = 1; a_out.tready = 1;
    @(negedge clk);
    chk("a_s0_vld", a_out.tvalid, 1);
    chk("a_s0_dat", a_out.tdata, d[255:0]);
    chk("a_s0_last", a_out.tlast, 0);
    chk("a_s0_in_rdy", a_in.tready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("a_s1_dat", a_out.tdata, d[511:256]);
    chk("a_s1_last", a_out.tlast, 1);
    chk("a_s1_in_rdy", a_in.tready, 1);
    @(posedge clk); #1;
    a_in.tvalid = 0;
    @(negedge clk);
    chk("a_idle_vld", a_out.tvalid, 0);
    @(posedge clk); #1;
    d = rnd512();
    a_in.tdata = d; a_in.tkeep = 64'h0000_0000_FFFF_FFFF; a_in.tlast = 0; a_in.tvalid = 1;
    @(negedge clk);
    chk("a_half_dat", a_out.tdata, d[255:0]);
    chk("a_half_in_rdy", a_in.tready, 1);
    @(posedge clk); #1;
    a_in.tvalid = 0;

    // 512->128 keep-pattern table
    for (int i = 0; i < 6; i++) begin
      d = rnd512();
      b_in.tdata = d; b_in.tkeep = tbl[i].keep; b_in.tlast = tbl[i].last; b_in.tvalid = 1; b_out.tready = 1;
      for (int s = 0; s < tbl[i].n; s++) begin
        @(negedge clk);
        chk($sformatf("tbl%0d_s%0d_dat", i, s), b_out.tdata, d[s*128 +: 128]);
        if (s == tbl[i].n - 1) chk($sformatf("tbl%0d_s%0d_keep", i, s), b_out.tkeep, tbl[i].fkeep);
        else chk($sformatf("tbl%0d_s%0d_keep", i, s), b_out.tkeep, tbl[i].keep[s*16 +: 16]);
        chk($sformatf("tbl%0d_s%0d_last", i, s), b_out.tlast, (s == tbl[i].n - 1) ? tbl[i].last : 1'b0);
        chk($sformatf("tbl%0d_s%0d_in_rdy", i, s), b_in.tready, s == tbl[i].n - 1);
        @(posedge clk); #1;
      end
    end
    b_in.tvalid = 0;

    // 512->128 output stall keeps slice 0 and the input
    d = rnd512();
    b_in.tdata = d; b_in.tkeep = '1; b_in.tlast = 0; b_in.tvalid = 1; b_out.tready = 0;
    @(posedge clk);
    @(negedge clk);
    chk("b_stall_dat", b_out.tdata, d[127:0]);
    chk("b_stall_in_rdy", b_in.tready, 0);
    @(posedge clk); #1;
    b_out.tready = 1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("b_drain_s%0d_dat", s), b_out.tdata, d[s*128 +: 128]);
      @(posedge clk); #1;
    end
    b_in.tvalid = 0;

    // 128->512 three beats, third closes the packet
    c_out.tready = 1;
    for (int k = 0; k < 3; k++) begin
      bq[k] = rnd512();
      c_in.tdata = bq[k]; c_in.tkeep = '1; c_in.tlast = (k == 2); c_in.tvalid = 1;
      @(negedge clk);
      chk($sformatf("c3_b%0d_in_rdy", k), c_in.tready, 1);
      chk($sformatf("c3_b%0d_out_vld", k), c_out.tvalid, 0);
      @(posedge clk); #1;
    end
    c_in.tvalid = 0; c_in.tlast = 0;
    @(negedge clk);
    chk("c3_vld", c_out.tvalid, 1);
    chk("c3_keep", c_out.tkeep, 64'h0000_FFFF_FFFF_FFFF);
    chk("c3_last", c_out.tlast, 1);
    chk("c3_dat", c_out.tdata, {128'h0, bq[2], bq[1], bq[0]});
    @(posedge clk); #1;
    @(negedge clk);
    chk("c3_drained", c_out.tvalid, 0);
    @(posedge clk); #1;

    // 128->512 empty tlast beat still produces a word
    c_in.tdata = rnd512(); c_in.tkeep = '0; c_in.tlast = 1; c_in.tvalid = 1;
    @(posedge clk); #1;
    c_in.tvalid = 0; c_in.tlast = 0;
    @(negedge clk);
    chk("c_empty_vld", c_out.tvalid, 1);
    chk("c_empty_keep", c_out.tkeep, 0);
    chk("c_empty_last", c_out.tlast, 1);
    @(posedge clk); #1;

    // 128->512 reset after one beat, then four fresh beats
    c_in.tdata = rnd512(); c_in.tkeep = '1; c_in.tlast = 0; c_in.tvalid = 1;
    @(posedge clk); #1;
    c_in.tvalid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      bq[k] = rnd512();
      c_in.tdata = bq[k]; c_in.tkeep = '1; c_in.tvalid = 1;
      @(posedge clk); #1;
    end
    c_in.tvalid = 0;
    @(negedge clk);
    chk("c_rst_vld", c_out.tvalid, 1);
    chk("c_rst_dat", c_out.tdata, {bq[3], bq[2], bq[1], bq[0]});
    chk("c_rst_keep", c_out.tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("c_rst_last", c_out.tlast, 0);
    @(posedge clk); #1;
    c_out.tready = 0;

    // 256->512 eight beats with tready toggling each cycle
    for (int k = 0; k < 8; k++) eb[k] = rnd512();
    bi = 0;
    cyc = 0;
    while ((bi < 8 || e_out.tvalid) && cyc < 60) begin
      e_out.tready = (cyc % 2 == 1);
      if (bi < 8) begin
        e_in.tvalid = 1; e_in.tdata = eb[bi]; e_in.tkeep = '1; e_in.tlast = (bi == 7);
      end else e_in.tvalid = 0;
      @(negedge clk);
      if (bi < 8) begin
        if ((bi % 2 == 1) && e_out.tvalid && !e_out.tready) chk("e_hold_in_rdy", e_in.tready, 0);
        else chk("e_in_rdy", e_in.tready, 1);
      end
      if (e_out.tvalid && e_out.tready) begin
        got.push_back(e_out.tdata);
        got_last.push_back(e_out.tlast);
      end
      hs = e_in.tvalid && e_in.tready;
      @(posedge clk); #1;
      cyc++;
      if (hs) bi++;
    end
    e_in.tvalid = 0;
    chk("e_timeout", cyc < 60, 1);
    chk("e_count", got.size(), 4);
    for (int w = 0; w < 4; w++) begin
      if (w < got.size()) begin
        chk($sformatf("e_w%0d_dat", w), got[w], {eb[2*w+1], eb[2*w]});
        chk($sformatf("e_w%0d_last", w), got_last[w], w == 3);
      end
    end

    // Random downsize 512->128 against slice-list model
    sent = 0; cyc = 0; busy = 0;
    expq.delete();
    while ((sent < 60 || busy || expq.size() > 0) && cyc < 3000) begin
      if (!busy && sent < 60 && $urandom_range(0, 3) != 0) begin
        d = rnd512();
        b_in.tdata = d; b_in.tkeep = rnd_keep(); b_in.tlast = $urandom_range(0, 1); b_in.tvalid = 1;
        hi = 0;
        for (int s = 0; s < 4; s++) if (b_in.tkeep[s*16 +: 16] != 0) hi = s;
        for (int s = 0; s <= hi; s++) begin
          e.d = {384'h0, d[s*128 +: 128]};
          e.k = {48'h0, b_in.tkeep[s*16 +: 16]};
          e.fin = (s == hi);
          e.l = b_in.tlast && (s == hi);
          expq.push_back(e);
        end
        busy = 1; sent++;
      end
      b_out.tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ohs = b_out.tvalid && b_out.tready;
      ihs = b_in.tvalid && b_in.tready;
      if (ohs) begin
        if (expq.size() == 0) chk("rb_extra_beat", 1, 0);
        else begin
          e = expq.pop_front();
          chk("rb_dat", b_out.tdata, e.d);
          chk("rb_keep", b_out.tkeep, e.k);
          chk("rb_last", b_out.tlast, e.l);
          chk("rb_in_consume", ihs, e.fin);
        end
      end else if (ihs) chk("rb_in_without_out", ihs, 0);
      @(posedge clk); #1;
      cyc++;
      if (ihs) begin busy = 0; b_in.tvalid = 0; end
    end
    b_in.tvalid = 0;
    chk("rb_timeout", cyc < 3000, 1);
    chk("rb_leftover", expq.size(), 0);

    // Random upsize 128->512 against lane-packing model
    sent = 0; cyc = 0; busy = 0; lanes = 0; hold = 0;
    cur.d = '0; cur.k = '0; cur.l = 0; cur.fin = 1;
    expq.delete();
    while ((sent < 80 || busy || expq.size() > 0) && cyc < 3000) begin
      if (!busy && sent < 80 && $urandom_range(0, 3) != 0) begin
        c_in.tdata = rnd512(); c_in.tkeep = rnd_keep(); c_in.tlast = ($urandom_range(0, 3) == 0); c_in.tvalid = 1;
        cur.d[lanes*128 +: 128] = c_in.tdata;
        cur.k[lanes*16 +: 16] = c_in.tkeep;
        lanes++;
        if (lanes == 4 || c_in.tlast) begin
          cur.l = c_in.tlast;
          expq.push_back(cur);
          cur.d = '0; cur.k = '0; lanes = 0;
        end
        busy = 1; sent++;
      end
      c_out.tready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold) begin
        chk("rc_hold_dat", c_out.tdata, hold_d);
        chk("rc_hold_keep", c_out.tkeep, hold_k);
        chk("rc_hold_last", c_out.tlast, hold_l);
      end
      hold = c_out.tvalid && !c_out.tready;
      hold_d = c_out.tdata; hold_k = c_out.tkeep; hold_l = c_out.tlast;
      ihs = c_in.tvalid && c_in.tready;
      if (c_out.tvalid && c_out.tready) begin
        if (expq.size() == 0) chk("rc_extra_word", 1, 0);
        else begin
          e = expq.pop_front();
          chk("rc_dat", c_out.tdata, e.d);
          chk("rc_keep", c_out.tkeep, e.k);
          chk("rc_last", c_out.tlast, e.l);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (ihs) begin busy = 0; c_in.tvalid = 0; end
    end
    c_in.tvalid = 0;
    chk("rc_timeout", cyc < 3000, 1);
    chk("rc_leftover", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_stream_resizer.md
AXI_STREAM_RESIZER -- requirements
Module: axi_stream_resizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 512, input tdata width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 256, output tdata width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in, AXI4S.s, IN_WIDTH data / IN_WIDTH/8 keep, the input stream: tdata, tkeep, tlast, tvalid, tready.
REQ-006 SHALL have port out, AXI4S.m, OUT_WIDTH data / OUT_WIDTH/8 keep, the output stream with the same signals.
REQ-007 SHALL fail elaboration unless both widths are powers of two, each is ≥8, and max/min ≤ 16; R = max/min.

Function
REQ-008 SHALL act as a pure passthrough when IN_WIDTH == OUT_WIDTH: all out signals wired to in, zero latency, no state.
REQ-009 Downsize (IN > OUT) SHALL split each input beat into slices s = 0..R-1, with slice s = tdata[s*OUT_WIDTH +: OUT_WIDTH] and the matching tkeep bits, emitted lowest slice first.
REQ-010 Downsize SHALL keep a slice index counter, width clog2(R), reset to 0; it increments on each out handshake and returns to 0 after the final slice of a beat.
REQ-011 Downsize final slice SHALL be the highest slice with any tkeep bit set; slice 0 when in.tkeep is all zero. Trailing all-zero-keep slices are never emitted.
REQ-012 Downsize SHALL drive out.tvalid = in.tvalid, and out.tlast = in.tlast only on the final slice.
REQ-013 Downsize SHALL drive in.tready = out.tready AND the current slice is final, so the input beat is consumed together with its final slice; output latency is 0 cycles.
REQ-014 Upsize (IN < OUT) SHALL collect input beats into a lane register, beat k going to lane k (LSB first), with a lane counter of width clog2(R) reset to 0.
REQ-015 Upsize SHALL complete a word when lane R-1 is written or when a beat with in.tlast=1 is accepted; unwritten lanes of that word get tkeep=0 and tdata=0.
REQ-016 Upsize SHALL present a completed word on a registered output one cycle after the completing input handshake, with out.tlast = tlast of the completing beat.
REQ-017 Upsize SHALL hold the output stable while out.tvalid=1 and out.tready=0.
REQ-018 Upsize SHALL drive in.tready = 1 while filling lanes 0..R-2; for a potentially completing beat, in.tready = !out.tvalid OR out.tready, so a word is emitted and the next one completed in the same cycle with full throughput.
REQ-019 Upsize SHALL return the lane counter to 0 and clear the staging keep after every completed word; a new packet never inherits lanes from the previous one.
REQ-020 Upsize, for a word with in.tlast=1 and in.tkeep=0, SHALL still emit the word (keep may be all zero) so that tlast is preserved.
REQ-021 Packet boundaries SHALL be preserved in both modes: exactly one out tlast per in tlast, and no bytes are reordered.

Reset
REQ-022 While rst=1, SHALL drive out.tvalid=0, counters=0, lane keep=0, and out.tdata/out.tkeep/out.tlast=0 in upsize.
REQ-023 Reset mid-packet SHALL discard partial words and slice progress; the first beat after reset starts at slice/lane 0.
REQ-024 In.tready SHALL be 0 while rst=1 in resizing modes.

Verification
REQ-025 512→256, full-keep beat with tlast=1, out.tready=1 → two out beats (low then high half), tlast only on the 2nd, in.tready high in the 2nd cycle only.
REQ-026 512→128, tkeep=64'h0000_0000_0000_FFFF, tlast=1 → exactly one out beat, keep=16'hFFFF, tlast=1, input consumed in the same cycle.
REQ-027 128→512, three full beats, the 3rd with tlast → one out beat the next cycle with keep=64'h0000_FFFF_FFFF_FFFF and tlast=1.
REQ-028 256→512 stream of 8 beats, out.tready toggled 1/0 every cycle → 4 words with data intact and no loss or duplication, in.tready deasserted whenever a completed word is held.
REQ-029 Assert rst after 1 beat of a 128→512 word, then send 4 fresh beats → the output word contains only the 4 new beats and keep is all ones.
